// File: rtl/ifetch_queue.sv
// -----------------------------------------------------------------------------
// ifetch_queue -- instruction fetch unit with a small prefetch queue.
//
// A three-state controller (IDLE / FETCH / DISCARD) issues sequential word
// fetches on a request/acknowledge instruction bus and pushes the returned
// instructions, tagged with their PC, into a DEPTH-entry circular queue.
// The queue head is presented to the decode stage. A redirect flushes the
// queue and restarts fetching at the (word-aligned) target. A request that
// is still pending when a redirect arrives is completed in DISCARD and its
// data is dropped.
//
// Optional feature (macro IFQ_BYPASS_EN): when the queue is empty, a word
// returned by a non-redirected transfer is forwarded combinationally to the
// head outputs. If the consumer takes it in that cycle, it is not queued.
//
// Ports:
//   CLK, RST       clock (rising edge), synchronous active-high reset
//   EN_PC          fetch enable; only gates new requests
//   redirect       taken branch/jump from execute
//   redirect_addr  redirect target (bits [1:0] ignored)
//   stall          consumer not accepting the head this cycle
//   mem_req        bus request, held with stable mem_addr until mem_ack
//   mem_addr       bus request address
//   mem_ack        bus accept; mem_rdata is valid in the same cycle
//   mem_rdata      returned instruction word
//   instr_valid    queue head valid
//   instr_out      head instruction (NOP when empty)
//   pc_out         head PC (zero when empty)
// -----------------------------------------------------------------------------
module ifetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            EN_PC,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_addr,
   input  logic            stall,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [31:0]     mem_rdata,
   output logic            instr_valid,
   output logic [31:0]     instr_out,
   output logic [XLEN-1:0] pc_out
);

   localparam int          PW  = $clog2(DEPTH);
   localparam int          CW  = PW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [XLEN-1:0] fetch_pc_reg;
   logic [XLEN-1:0] req_addr_reg;   // address of the request last issued in FETCH
   logic [CW-1:0]   count_reg;
   logic [PW-1:0]   rd_ptr_reg;
   logic [PW-1:0]   wr_ptr_reg;

   logic [31:0]     instr_mem [DEPTH];
   logic [XLEN-1:0] pc_mem    [DEPTH];

   logic            transfer;
   logic            fetch_xfer;
   logic            bypass_hit;
   logic            queue_valid;
   logic            pop;
   logic            push;
   logic [CW-1:0]   count_after;

   assign transfer    = mem_req && mem_ack;
   // A transfer whose data is kept (not stale, not killed by a redirect).
   assign fetch_xfer  = (state_reg == FETCH) && transfer && !redirect;
   assign queue_valid = (count_reg != '0);

`ifdef IFQ_BYPASS_EN
   assign bypass_hit  = fetch_xfer && !queue_valid;
`else
   assign bypass_hit  = 1'b0;
`endif

   // Queue pop only; a bypassed word consumed directly never enters the queue.
   assign pop         = queue_valid && !stall && !redirect;
   assign push        = fetch_xfer && !(bypass_hit && !stall);
   assign count_after = count_reg + CW'(push) - CW'(pop);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (!redirect && EN_PC && (count_reg < CW'(DEPTH)))
               state_next = FETCH;
         end
         FETCH: begin
            if (redirect) begin
               // A transfer completing with the redirect is simply dropped;
               // otherwise the outstanding request must still be drained.
               if (transfer)
                  state_next = EN_PC ? FETCH : IDLE;
               else
                  state_next = DISCARD;
            end else if (transfer) begin
               state_next = (EN_PC && (count_after < CW'(DEPTH))) ? FETCH : IDLE;
            end
         end
         DISCARD: begin
            if (transfer)
               state_next = FETCH;
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      mem_req  = (state_reg != IDLE);
      // In DISCARD the stale address must stay on the bus until accepted.
      mem_addr = (state_reg == FETCH) ? fetch_pc_reg : req_addr_reg;
   end

   always_comb begin
      instr_valid = queue_valid;
      instr_out   = NOP;
      pc_out      = '0;
      if (queue_valid) begin
         instr_out = instr_mem[rd_ptr_reg];
         pc_out    = pc_mem[rd_ptr_reg];
      end else if (bypass_hit) begin
         instr_valid = 1'b1;
         instr_out   = mem_rdata;
         pc_out      = fetch_pc_reg;
      end
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge CLK) begin
      if (RST) begin
         fetch_pc_reg <= RESET_PC;
         req_addr_reg <= RESET_PC;
         count_reg    <= '0;
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
      end else begin
         if (state_reg == FETCH)
            req_addr_reg <= fetch_pc_reg;

         if (redirect) begin
            fetch_pc_reg <= redirect_addr & ~XLEN'(3);
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
         end else begin
            if (fetch_xfer)
               fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
            // Pointers are PW bits wide, so they wrap modulo DEPTH for free.
            if (push)
               wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
               rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_after;
         end
      end
   end

   // Queue storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge CLK) begin
      if (push && !RST) begin
         instr_mem[wr_ptr_reg] <= mem_rdata;
         pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
      end
   end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameters SHALL be:
- XLEN, 32, address/data width.
- DEPTH, 4, queue entries (power of 2, ≥2).
- RESET_PC, 32'h0, first fetch address.
REQ-002 Ports SHALL be, in this order:
- CLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- EN_PC  in  1  fetch enable.
- redirect  in  1  PC change (taken branch/jump) from execute.
- redirect_addr  in  XLEN  redirect target.
- stall  in  1  consumer not accepting (hazard stall).
- mem_req  out  1  instruction-bus request.
- mem_addr  out  XLEN  request address.
- mem_ack  in  1  bus accept; data returned same cycle.
- mem_rdata  in  32  returned instruction.
- instr_valid  out  1  queue head valid.
- instr_out  out  32  head instruction.
- pc_out  out  XLEN  head PC.
REQ-003 One clock; reset is synchronous and active-high; ports named CLK and RST.

Function
REQ-004 Bus transfer SHALL occur in any cycle where mem_req=1 and mem_ack=1.
REQ-005 Once raised, mem_req SHALL stay high with mem_addr unchanged until a transfer occurs.
REQ-006 FSM states SHALL be:
- IDLE: mem_req=0.
- FETCH: mem_req=1, addr=fetch_pc.
- DISCARD: mem_req=1, stale address; returned data dropped.
REQ-007 IDLE SHALL go to FETCH when EN_PC=1, redirect=0 and count<DEPTH.
REQ-008 FETCH transitions on transfer:
- no redirect: push {fetch_pc, mem_rdata}; fetch_pc += 4.
- then stay in FETCH if EN_PC=1 and post-update count<DEPTH, else IDLE.
REQ-009 Redirect in FETCH without mem_ack SHALL go to DISCARD.
REQ-010 DISCARD on transfer SHALL drop the data and go to FETCH at the redirect target.
REQ-011 Redirect in any state SHALL, next edge:
- set count=0;
- set fetch_pc=redirect_addr with bits[1:0] forced to 0;
- discard any same-cycle transfer data.
REQ-012 A pop SHALL occur when instr_valid=1 and stall=0 and redirect=0.
REQ-013 Simultaneous push and pop SHALL leave count unchanged.
REQ-014 instr_valid SHALL equal (count!=0).
REQ-015 Read/write pointers SHALL wrap modulo DEPTH.
REQ-016 Latency: transfer into an empty queue at edge N SHALL give instr_valid=1 in cycle N+1.
REQ-017 EN_PC=0 SHALL NOT abort a pending request; it only blocks new ones.

Reset
REQ-018 With RST=1 at an edge:
- state=IDLE; mem_req=0; mem_addr=RESET_PC.
- fetch_pc=RESET_PC; count=0; pointers=0.
- instr_valid=0; instr_out=32'h00000013 (NOP); pc_out=0.
REQ-019 RST SHALL override redirect and mem_ack in the same cycle; an in-flight transfer is abandoned.

Configuration
REQ-020 Macro IFQ_BYPASS_EN defined:
- When count=0 and a non-redirected transfer occurs, drive instr_valid=1, instr_out=mem_rdata, pc_out=fetch_pc combinationally.
- If stall=0 that cycle, the word SHALL NOT be pushed.
REQ-021 IFQ_BYPASS_EN undefined: no bypass path; latency per REQ-016.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Reset, EN_PC=1, mem_ack always 1, stall=0 -> addresses 0,4,8,...; first instr_valid in cycle 2 (cycle 1 with bypass); pc_out increments by 4.
- stall=1 held, mem_ack=1 -> exactly 4 pushes; mem_req=0 once count=4; stall=0 -> heads 0,4,8,C in order.
- mem_ack=0 for 3 cycles -> mem_req and mem_addr stable throughout.
- redirect=1, redirect_addr=0x103 with request pending and no ack -> DISCARD; ack data dropped; next request at 0x100; no stale instr_valid.
- redirect and mem_ack in the same cycle -> data dropped; count=0; next mem_addr=target.
- RST asserted mid-FETCH with count=2 -> next cycle instr_valid=0, mem_req=0, instr_out=0x00000013.
